// File: rtl/ppu_spr_fetch.sv
// rtl/ppu_spr_fetch.sv - sprite fetch sequencer: secondary OAM + VRAM pattern reads into per-slot shifter loads
module ppu_spr_fetch #(
  parameter int NSLOT = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [3:0]       i_sprite_cnt,
  input  logic [7:0]       i_scanline,
  input  logic             i_spr_size16,
  input  logic             i_spr_pt_sel,
  output logic [4:0]       o_soam_addr,
  input  logic [7:0]       i_soam_data,
  output logic             o_vram_req,
  output logic [13:0]      o_vram_addr,
  input  logic             i_vram_ack,
  input  logic [7:0]       i_vram_data,
  output logic [7:0]       o_xcnt,
  output logic [NSLOT-1:0] o_xcnt_wr,
  output logic [7:0]       o_attr,
  output logic [NSLOT-1:0] o_attr_we,
  output logic [15:0]      o_patt,
  output logic [NSLOT-1:0] o_patt_we,
  output logic             o_busy,
  output logic             o_done
);

  localparam int SW = $clog2(NSLOT);

  typedef enum logic [3:0] {
    S_IDLE, S_RDY, S_RDT, S_RDA, S_RDX, S_LO, S_HI, S_WR, S_EMPTY, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      scan_q, scan_d;
  logic            size16_q, size16_d;
  logic            pt_q, pt_d;
  logic [7:0]      y_q, y_d;
  logic [7:0]      tile_q, tile_d;
  logic            vflip_q, vflip_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic            lo_first_q, lo_first_d;

  logic [NSLOT-1:0] slot_oh;
  logic [3:0]       cnt_clamp;
  logic [3:0]       slot_next;
  logic [3:0]       row_raw;
  logic [3:0]       row;
  logic             plane;
  logic [13:0]      addr_calc;

  assign slot_oh   = {{(NSLOT-1){1'b0}}, 1'b1} << slot_q;
  assign cnt_clamp = (i_sprite_cnt > 4'(NSLOT)) ? 4'(NSLOT) : i_sprite_cnt;
  assign slot_next = 4'(slot_q) + 4'd1;

  // Only the low nibble of (scanline - Y) selects a row; mod-16 subtraction is enough.
  assign row_raw = 4'(scan_q - y_q);
  assign row     = vflip_q ? (size16_q ? ~row_raw : {row_raw[3], ~row_raw[2:0]}) : row_raw;
  assign plane   = (state_q == S_HI);

  assign addr_calc = size16_q ? {1'b0, tile_q[0], tile_q[7:1], row[3], plane, row[2:0]}
                              : {1'b0, pt_q, tile_q, plane, row[2:0]};

  assign o_vram_addr = o_vram_req ? addr_calc : 14'd0;
  assign o_busy      = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    size16_d   = size16_q;
    pt_d       = pt_q;
    y_d        = y_q;
    tile_d     = tile_q;
    vflip_d    = vflip_q;
    x_d        = x_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    lo_first_d = lo_first_q;
    o_soam_addr = 5'd0;
    o_vram_req  = 1'b0;
    o_xcnt      = 8'd0;
    o_xcnt_wr   = '0;
    o_attr      = 8'd0;
    o_attr_we   = '0;
    o_patt      = 16'd0;
    o_patt_we   = '0;
    o_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cnt_d    = cnt_clamp;
          scan_d   = i_scanline;
          size16_d = i_spr_size16;
          pt_d     = i_spr_pt_sel;
          slot_d   = '0;
          state_d  = (cnt_clamp != 4'd0) ? S_RDY : S_EMPTY;
        end
      end
      S_RDY: begin
        o_soam_addr = 5'({slot_q, 2'd0});
        state_d     = S_RDT;
      end
      S_RDT: begin
        o_soam_addr = 5'({slot_q, 2'd1});
        y_d         = i_soam_data;
        state_d     = S_RDA;
      end
      S_RDA: begin
        o_soam_addr = 5'({slot_q, 2'd2});
        tile_d      = i_soam_data;
        state_d     = S_RDX;
      end
      S_RDX: begin
        o_soam_addr = 5'({slot_q, 2'd3});
        o_attr      = i_soam_data;
        o_attr_we   = slot_oh;
        vflip_d     = i_soam_data[7];
        lo_first_d  = 1'b1;
        state_d     = S_LO;
      end
      S_LO: begin
        o_vram_req = 1'b1;
        // X byte is only on the OAM bus for the first LO cycle, even if VRAM stalls.
        if (lo_first_q) begin
          x_d        = i_soam_data;
          lo_first_d = 1'b0;
        end
        if (i_vram_ack) begin
          lo_d    = i_vram_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        o_vram_req = 1'b1;
        if (i_vram_ack) begin
          hi_d    = i_vram_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        o_patt    = {hi_q, lo_q};
        o_xcnt    = x_q;
        o_patt_we = slot_oh;
        o_xcnt_wr = slot_oh;
        if (slot_q == SW'(NSLOT - 1)) begin
          state_d = S_DONE;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = (slot_next < cnt_q) ? S_RDY : S_EMPTY;
        end
      end
      S_EMPTY: begin
        o_attr_we = slot_oh;
        hi_d      = 8'd0;
        lo_d      = 8'd0;
        x_d       = 8'hFF;
        state_d   = S_WR;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      cnt_q      <= 4'd0;
      scan_q     <= 8'd0;
      size16_q   <= 1'b0;
      pt_q       <= 1'b0;
      y_q        <= 8'd0;
      tile_q     <= 8'd0;
      vflip_q    <= 1'b0;
      x_q        <= 8'd0;
      lo_q       <= 8'd0;
      hi_q       <= 8'd0;
      lo_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      size16_q   <= size16_d;
      pt_q       <= pt_d;
      y_q        <= y_d;
      tile_q     <= tile_d;
      vflip_q    <= vflip_d;
      x_q        <= x_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      lo_first_q <= lo_first_d;
    end
  end

endmodule

// File: tb/tb_ppu_spr_fetch.sv
// tb/tb_ppu_spr_fetch.sv - directed scoreboard bench for the sprite fetch sequencer
`timescale 1ns/1ps
module tb_ppu_spr_fetch;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [3:0]  i_sprite_cnt = 4'd0;
  logic [7:0]  i_scanline = 8'd0;
  logic        i_spr_size16 = 1'b0;
  logic        i_spr_pt_sel = 1'b0;
  logic [4:0]  o_soam_addr;
  logic [7:0]  i_soam_data = 8'd0;
  logic        o_vram_req;
  logic [13:0] o_vram_addr;
  logic        i_vram_ack = 1'b0;
  logic [7:0]  i_vram_data = 8'd0;
  logic [7:0]  o_xcnt;
  logic [7:0]  o_xcnt_wr;
  logic [7:0]  o_attr;
  logic [7:0]  o_attr_we;
  logic [15:0] o_patt;
  logic [7:0]  o_patt_we;
  logic        o_busy;
  logic        o_done;

  ppu_spr_fetch #(.NSLOT(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_sprite_cnt(i_sprite_cnt),
    .i_scanline(i_scanline), .i_spr_size16(i_spr_size16), .i_spr_pt_sel(i_spr_pt_sel),
    .o_soam_addr(o_soam_addr), .i_soam_data(i_soam_data), .o_vram_req(o_vram_req),
    .o_vram_addr(o_vram_addr), .i_vram_ack(i_vram_ack), .i_vram_data(i_vram_data),
    .o_xcnt(o_xcnt), .o_xcnt_wr(o_xcnt_wr), .o_attr(o_attr), .o_attr_we(o_attr_we),
    .o_patt(o_patt), .o_patt_we(o_patt_we), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          kind;   // 0 attr write, 1 pattern/X write, 2 VRAM read, 3 done
    int          slot;
    logic [15:0] d;
    logic [7:0]  x;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  int         ack_dly = 0;
  logic [7:0] soam [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] vdata(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
  endfunction

  function automatic logic [13:0] exp_addr(input logic [7:0] y, input logic [7:0] t,
                                           input logic [7:0] a, input logic [7:0] scan,
                                           input logic s16, input logic pt, input logic pl);
    logic [7:0] rw;
    logic [3:0] r;
    rw = scan - y;
    r  = rw[3:0];
    if (a[7]) r = s16 ? ~r : {r[3], ~r[2:0]};
    if (s16) return {1'b0, t[0], t[7:1], r[3], pl, r[2:0]};
    return {1'b0, pt, t, pl, r[2:0]};
  endfunction

  task automatic set_slot(input int s, input logic [7:0] y, input logic [7:0] t,
                          input logic [7:0] a, input logic [7:0] x);
    soam[4*s]   = y;
    soam[4*s+1] = t;
    soam[4*s+2] = a;
    soam[4*s+3] = x;
  endtask

  task automatic push_valid(input int s, input logic [7:0] a, input logic [7:0] x,
                            input logic [13:0] lo, input logic [13:0] hi);
    q.push_back('{0, s, {8'h00, a}, 8'h00});
    q.push_back('{2, s, {2'b00, lo}, 8'h00});
    q.push_back('{2, s, {2'b00, hi}, 8'h00});
    q.push_back('{1, s, {vdata(hi), vdata(lo)}, x});
  endtask

  task automatic push_empties(input int first);
    for (int s = first; s < 8; s++) begin
      q.push_back('{0, s, 16'h0000, 8'h00});
      q.push_back('{1, s, 16'h0000, 8'hFF});
    end
    q.push_back('{3, 0, 16'h0000, 8'h00});
  endtask

  task automatic pop_ev(output ev_t e, output bit ok);
    if (q.size() == 0) begin
      ok = 1'b0;
      e  = '{-1, -1, 16'h0, 8'h0};
      chk("unexpected_event", 1, 0);
    end else begin
      ok = 1'b1;
      e  = q.pop_front();
    end
  endtask

  // Secondary OAM: data valid the cycle after the address.
  initial begin
    logic [4:0] a;
    forever begin
      @(negedge i_clk);
      a = o_soam_addr;
      @(posedge i_clk);
      #1 i_soam_data = soam[a];
    end
  end

  // VRAM responder with programmable ack latency; non-ack cycles carry junk data.
  initial begin
    int          wcnt;
    logic [13:0] held;
    ev_t         e;
    bit          ok;
    wcnt = 0;
    held = '0;
    forever begin
      @(negedge i_clk);
      i_vram_ack  = 1'b0;
      i_vram_data = 8'hEE;
      if (!o_vram_req || !i_rstn) begin
        wcnt = 0;
      end else begin
        if (wcnt > 0) chk("vram_addr_stable", o_vram_addr, held);
        held = o_vram_addr;
        if (wcnt >= ack_dly) begin
          i_vram_ack  = 1'b1;
          i_vram_data = vdata(o_vram_addr);
          wcnt = 0;
          pop_ev(e, ok);
          if (ok) begin
            chk("vram_kind", e.kind, 2);
            chk("vram_addr", o_vram_addr, e.d);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Strobe monitor: every strobe must match the next scoreboard entry.
  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        if (o_attr_we != 8'h00) begin
          pop_ev(e, ok);
          if (ok) begin
            chk("attr_kind", e.kind, 0);
            chk("attr_we", o_attr_we, 32'(1) << e.slot);
            chk("attr_val", o_attr, e.d[7:0]);
          end
        end
        if (o_patt_we != 8'h00 || o_xcnt_wr != 8'h00) begin
          pop_ev(e, ok);
          if (ok) begin
            chk("patt_kind", e.kind, 1);
            chk("patt_we", o_patt_we, 32'(1) << e.slot);
            chk("xcnt_wr", o_xcnt_wr, 32'(1) << e.slot);
            chk("patt_val", o_patt, e.d);
            chk("xcnt_val", o_xcnt, e.x);
          end
        end
        if (o_done) begin
          pop_ev(e, ok);
          if (ok) chk("done_kind", e.kind, 3);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_req"}, o_vram_req, 0);
    chk({tag, "_vaddr"}, o_vram_addr, 0);
    chk({tag, "_saddr"}, o_soam_addr, 0);
    chk({tag, "_strobes"}, {o_attr_we, o_patt_we, o_xcnt_wr}, 0);
    chk({tag, "_data"}, {o_attr, o_patt, o_xcnt}, 0);
  endtask

  task automatic run(input int cnt, input logic [7:0] scan, input logic s16, input logic pt,
                     input int dly, input int exp_cyc, input int poke);
    int n;
    ack_dly = dly;
    @(negedge i_clk);
    i_sprite_cnt = 4'(cnt);
    i_scanline   = scan;
    i_spr_size16 = s16;
    i_spr_pt_sel = pt;
    i_start      = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 2000) begin
      if (n == 2) chk("busy_mid", o_busy, 1);
      i_start = (n == poke);
      if (n == poke) i_sprite_cnt = 4'd8;
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    chk("done_cycle", n, exp_cyc);
    @(negedge i_clk);
    chk("queue_drained", q.size(), 0);
    chk("idle_busy", o_busy, 0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) soam[i] = 8'h00;

    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rstn = 1'b1;

    // No sprites: eight empty slots, a stray start mid-run is ignored.
    push_empties(0);
    run(0, 8'h00, 1'b0, 1'b0, 0, 17, 5);

    // 8x8, pt_sel=1, no flip.
    set_slot(0, 8'h10, 8'h42, 8'h01, 8'h30);
    push_valid(0, 8'h01, 8'h30, 14'h1423, 14'h142B);
    push_empties(1);
    run(1, 8'h13, 1'b0, 1'b1, 0, 22, -1);

    // 8x8 with vflip.
    set_slot(0, 8'h10, 8'h42, 8'h80, 8'h30);
    push_valid(0, 8'h80, 8'h30, 14'h1424, 14'h142C);
    push_empties(1);
    run(1, 8'h13, 1'b0, 1'b1, 0, 22, -1);

    // 8x16, row 9, plain and vflipped.
    set_slot(0, 8'h17, 8'h43, 8'h00, 8'h11);
    set_slot(1, 8'h17, 8'h43, 8'h80, 8'h22);
    push_valid(0, 8'h00, 8'h11, 14'h1431, 14'h1439);
    push_valid(1, 8'h80, 8'h22, 14'h1426, 14'h142E);
    push_empties(2);
    run(2, 8'h20, 1'b1, 1'b0, 0, 27, -1);

    // Slow VRAM: three wait cycles per plane.
    set_slot(0, 8'h10, 8'h42, 8'h01, 8'h30);
    push_valid(0, 8'h01, 8'h30, 14'h1423, 14'h142B);
    push_empties(1);
    run(1, 8'h13, 1'b0, 1'b1, 3, 28, -1);

    // Count above 8 clamps to all eight slots valid; rows wrap past zero.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] y, t, a, x;
      y = 8'h50 + 8'(i);
      t = 8'h10 * 8'(i) + 8'h03;
      a = {i[0], 7'(i)};
      x = 8'h20 + 8'(i * 8);
      set_slot(i, y, t, a, x);
      push_valid(i, a, x, exp_addr(y, t, a, 8'h55, 1'b0, 1'b0, 1'b0),
                 exp_addr(y, t, a, 8'h55, 1'b0, 1'b0, 1'b1));
    end
    q.push_back('{3, 0, 16'h0000, 8'h00});
    run(12, 8'h55, 1'b0, 1'b0, 0, 57, -1);

    // Async reset while waiting on the plane-1 read.
    set_slot(0, 8'h10, 8'h42, 8'h01, 8'h30);
    push_valid(0, 8'h01, 8'h30, 14'h1423, 14'h142B);
    push_empties(1);
    ack_dly = 3;
    @(negedge i_clk);
    i_sprite_cnt = 4'd1;
    i_scanline   = 8'h13;
    i_spr_size16 = 1'b0;
    i_spr_pt_sel = 1'b1;
    i_start      = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_vram_req && o_vram_addr[3]) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("reached_hi", {31'd0, o_vram_req && o_vram_addr[3]}, 1);
    #2 i_rstn = 1'b0;
    #1 chk_all_zero("midreset");
    q.delete();
    @(negedge i_clk);
    chk_all_zero("held_reset");
    i_rstn = 1'b1;

    set_slot(0, 8'h10, 8'h42, 8'h01, 8'h30);
    push_valid(0, 8'h01, 8'h30, 14'h1423, 14'h142B);
    push_empties(1);
    run(1, 8'h13, 1'b0, 1'b1, 0, 22, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
